// File: rtl/int_pkg.sv
// int_pkg: shared state type, source indices, register bit positions and vector defaults
package int_pkg;
  typedef enum logic {IDLE, REQ} state_e;
  localparam int SRC_IE0 = 0;
  localparam int SRC_TF0 = 1;
  localparam int SRC_IE1 = 2;
  localparam int SRC_TF1 = 3;
  localparam int SRC_SER = 4;
  localparam int NSRC = 5;
  localparam int IE_EA = 7;
  localparam logic [15:0] DEF_VEC_BASE = 16'h0003;
  localparam int DEF_VEC_STRIDE = 8;
  // timer flags and edge-mode externals are cleared by hardware on acceptance
  function automatic logic [NSRC-1:0] clr_mask(input logic [1:0] it);
    clr_mask = '0;
    clr_mask[SRC_IE0] = it[0];
    clr_mask[SRC_TF0] = 1'b1;
    clr_mask[SRC_IE1] = it[1];
    clr_mask[SRC_TF1] = 1'b1;
  endfunction
endpackage

// File: rtl/int_prio_encoder.sv
// int_prio_encoder: in-service eligibility masking and two-group fixed-priority select
module int_prio_encoder
  import int_pkg::*;
(
  input  logic [NSRC-1:0] pending_i,
  input  logic [NSRC-1:0] ip_i,
  input  logic            isl_i,
  input  logic            ish_i,
  output logic            valid_o,
  output logic [2:0]      idx_o,
  output logic            level_o
);
  logic [NSRC-1:0] elig, hi, grp;
  assign elig = ish_i ? '0 : isl_i ? pending_i & ip_i : pending_i;
  assign hi = elig & ip_i;
  assign grp = |hi ? hi : elig & ~ip_i;
  assign valid_o = |elig;
  assign level_o = |hi;
  always_comb begin
    idx_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (grp[i]) idx_o = 3'(i);
  end
endmodule

// File: rtl/interrupt_requester.sv
// interrupt_requester: 8051 interrupt arbitration, int_req/int_ack initiator, two-level nesting
// Optional ack timeout enabled by defining INT_ACK_TIMEOUT_EN.
module interrupt_requester
  import int_pkg::*;
#(
  parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
  parameter int          VEC_STRIDE = DEF_VEC_STRIDE
`ifdef INT_ACK_TIMEOUT_EN
  , parameter int        ACK_TIMEOUT = 16
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  irq_src,
  input  logic [1:0]  it,
  input  logic [7:0]  ie_reg,
  input  logic [7:0]  ip_reg,
  input  logic        int_ack,
  input  logic        reti,
  output logic        int_req,
  output logic [15:0] int_vec,
  output logic [2:0]  int_src,
  output logic [4:0]  clr_flag,
  output logic        timeout
);
  state_e      state_q;
  logic        req_q, lvl_q, hold_q, isl_q, ish_q, isl_d, ish_d;
  logic [15:0] vec_q;
  logic [2:0]  src_q, sel_idx;
  logic [4:0]  clr_q, pending;
  logic        sel_valid, sel_lvl, accept, expire;
  logic        unused_bits;
  assign unused_bits = ^{ie_reg[6:5], ip_reg[7:5]};
  assign pending = irq_src & ie_reg[4:0] & {5{ie_reg[IE_EA]}};
  assign accept = state_q == REQ && int_ack;
  // reti retires the most recent level first; an ack in the same cycle then claims its level
  assign ish_d = (accept && lvl_q) | (ish_q & ~reti);
  assign isl_d = (accept && !lvl_q) | (isl_q & ~(reti & ~ish_q));
  int_prio_encoder u_enc (
    .pending_i (pending),
    .ip_i      (ip_reg[4:0]),
    .isl_i     (isl_q),
    .ish_i     (ish_q),
    .valid_o   (sel_valid),
    .idx_o     (sel_idx),
    .level_o   (sel_lvl)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      vec_q   <= '0;
      src_q   <= '0;
      lvl_q   <= 1'b0;
      clr_q   <= '0;
      hold_q  <= 1'b0;
      isl_q   <= 1'b0;
      ish_q   <= 1'b0;
    end else begin
      clr_q  <= '0;
      hold_q <= 1'b0;
      isl_q  <= isl_d;
      ish_q  <= ish_d;
      if (state_q == IDLE) begin
        if (sel_valid && !hold_q) begin
          state_q <= REQ;
          req_q   <= 1'b1;
          src_q   <= sel_idx;
          lvl_q   <= sel_lvl;
          vec_q   <= VEC_BASE + 16'(VEC_STRIDE) * 16'(sel_idx);
        end
      end else if (int_ack) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
        clr_q   <= clr_mask(it) & (5'b1 << src_q);
        hold_q  <= 1'b1;
      end else if (!pending[src_q] || expire) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
      end
    end
  end
`ifdef INT_ACK_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  logic [CW-1:0] cnt_q;
  logic          to_q;
  assign expire = state_q == REQ && !int_ack && pending[src_q] && cnt_q == CW'(ACK_TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= (state_q == REQ && !int_ack) ? cnt_q + 1'b1 : '0;
      if (expire) to_q <= 1'b1;
    end
  end
  assign timeout = to_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif
  assign int_req  = req_q;
  assign int_vec  = vec_q;
  assign int_src  = src_q;
  assign clr_flag = clr_q;
endmodule

// File: tb/tb_interrupt_requester.sv
// tb_interrupt_requester: vector table, directed nesting/withdraw/reset sequences, randomized run vs reference model
module tb_interrupt_requester;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  irq_src = '0;
  logic [1:0]  it = '0;
  logic [7:0]  ie_reg = '0;
  logic [7:0]  ip_reg = '0;
  logic        int_ack = 1'b0;
  logic        reti = 1'b0;
  logic        int_req;
  logic [15:0] int_vec;
  logic [2:0]  int_src;
  logic [4:0]  clr_flag;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  int       svc[$];
  int       req_src = -1;
  int       req_lvl = 0;
  int       age = 0;
  bit       gap = 0;
  bit       exp_to = 0;
  logic [4:0] exp_clr = '0;

  typedef struct {
    logic [4:0]  irq;
    logic [1:0]  itv;
    logic [7:0]  ie;
    logic        ack;
    logic        rt;
    logic        req;
    logic [15:0] vec;
    logic [2:0]  src;
    logic [4:0]  clr;
  } row_t;
  row_t tbl[13];

  interrupt_requester dut (
    .clock    (clock),
    .reset    (reset),
    .irq_src  (irq_src),
    .it       (it),
    .ie_reg   (ie_reg),
    .ip_reg   (ip_reg),
    .int_ack  (int_ack),
    .reti     (reti),
    .int_req  (int_req),
    .int_vec  (int_vec),
    .int_src  (int_src),
    .clr_flag (clr_flag),
    .timeout  (timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit clearable(input int i, input logic [1:0] itv);
    return i == 1 || i == 3 || (i == 0 && itv[0]) || (i == 2 && itv[1]);
  endfunction

  // reference model: in-service levels as a stack; a source qualifies when its level beats the top
  task automatic step();
    logic [4:0] pend;
    int top, best, bs, sc;
    pend = irq_src & ie_reg[4:0] & {5{ie_reg[7]}};
    top = svc.size() == 0 ? -1 : svc[$];
    exp_clr = '0;
    if (reset) begin
      svc.delete();
      req_src = -1;
      gap = 0;
      exp_to = 0;
      age = 0;
    end else begin
      if (reti && svc.size() > 0) void'(svc.pop_back());
      if (req_src >= 0) begin
        if (int_ack) begin
          svc.push_back(req_lvl);
          if (clearable(req_src, it)) exp_clr[req_src] = 1'b1;
          req_src = -1;
          gap = 1;
        end else if (!pend[req_src]) req_src = -1;
`ifdef INT_ACK_TIMEOUT_EN
        else begin
          age++;
          if (age == 16) begin
            req_src = -1;
            exp_to = 1;
          end
        end
`endif
      end else if (gap) gap = 0;
      else begin
        best = -1;
        bs = -1;
        for (int i = 0; i < 5; i++) begin
          sc = int'(ip_reg[i]) * 10 + 4 - i;
          if (pend[i] && int'(ip_reg[i]) > top && sc > bs) begin
            best = i;
            bs = sc;
          end
        end
        if (best >= 0) begin
          req_src = best;
          req_lvl = int'(ip_reg[best]);
          age = 0;
        end
      end
    end
    @(posedge clock);
    #1;
    chk("mdl_req", int_req, req_src >= 0);
    if (req_src >= 0) begin
      chk("mdl_vec", int_vec, 16'h0003 + 16'(8 * req_src));
      chk("mdl_src", int_src, req_src);
    end
    chk("mdl_clr", clr_flag, exp_clr);
    chk("mdl_timeout", timeout, exp_to);
  endtask

  task automatic cyc(input logic [4:0] irq, input logic ack, input logic rt);
    irq_src = irq;
    int_ack = ack;
    reti = rt;
    step();
    int_ack = 1'b0;
    reti = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    irq_src = '0;
    int_ack = 1'b0;
    reti = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] irq;
    tbl[0]  = '{5'b00001, 2'b01, 8'h81, 0, 0, 1, 16'h0003, 3'd0, 5'b00000};
    tbl[1]  = '{5'b00001, 2'b01, 8'h81, 1, 0, 0, 16'h0000, 3'd0, 5'b00001};
    tbl[2]  = '{5'b00000, 2'b01, 8'h81, 0, 0, 0, 16'h0000, 3'd0, 5'b00000};
    tbl[3]  = '{5'b00000, 2'b01, 8'h81, 0, 1, 0, 16'h0000, 3'd0, 5'b00000};
    tbl[4]  = '{5'b00110, 2'b00, 8'h86, 0, 0, 1, 16'h000B, 3'd1, 5'b00000};
    tbl[5]  = '{5'b00110, 2'b00, 8'h86, 1, 0, 0, 16'h0000, 3'd0, 5'b00010};
    tbl[6]  = '{5'b00100, 2'b00, 8'h86, 0, 0, 0, 16'h0000, 3'd0, 5'b00000};
    tbl[7]  = '{5'b00100, 2'b00, 8'h86, 0, 1, 0, 16'h0000, 3'd0, 5'b00000};
    tbl[8]  = '{5'b00100, 2'b00, 8'h86, 0, 0, 1, 16'h0013, 3'd2, 5'b00000};
    tbl[9]  = '{5'b00100, 2'b00, 8'h86, 1, 0, 0, 16'h0000, 3'd0, 5'b00000};
    tbl[10] = '{5'b00100, 2'b00, 8'h86, 0, 1, 0, 16'h0000, 3'd0, 5'b00000};
    tbl[11] = '{5'b00100, 2'b00, 8'h86, 0, 0, 1, 16'h0013, 3'd2, 5'b00000};
    tbl[12] = '{5'b00000, 2'b00, 8'h86, 0, 0, 0, 16'h0000, 3'd0, 5'b00000};

    do_reset();
    do_reset();
    chk("rst_req", int_req, 0);
    chk("rst_vec", int_vec, 16'h0000);
    chk("rst_src", int_src, 0);
    chk("rst_clr", clr_flag, 0);
    chk("rst_timeout", timeout, 0);

    for (int r = 0; r < 13; r++) begin
      it = tbl[r].itv;
      ie_reg = tbl[r].ie;
      cyc(tbl[r].irq, tbl[r].ack, tbl[r].rt);
      chk($sformatf("tbl%0d_req", r), int_req, tbl[r].req);
      if (tbl[r].req) begin
        chk($sformatf("tbl%0d_vec", r), int_vec, tbl[r].vec);
        chk($sformatf("tbl%0d_src", r), int_src, tbl[r].src);
      end
      chk($sformatf("tbl%0d_clr", r), clr_flag, tbl[r].clr);
    end

    do_reset();
    ie_reg = 8'h8D;
    it = 2'b11;
    ip_reg = 8'h01;
    cyc(5'b01000, 0, 0);
    chk("nest_tf1_vec", int_vec, 16'h001B);
    cyc(5'b01000, 1, 0);
    chk("nest_tf1_clr", clr_flag, 5'b01000);
    cyc(5'b00000, 0, 0);
    cyc(5'b00101, 0, 0);
    chk("nest_pre_req", int_req, 1);
    chk("nest_pre_vec", int_vec, 16'h0003);
    cyc(5'b00101, 1, 0);
    chk("nest_ie0_clr", clr_flag, 5'b00001);
    for (int k = 0; k < 3; k++) begin
      cyc(5'b00100, 0, 0);
      chk("nest_hold_hi", int_req, 0);
    end
    cyc(5'b00100, 0, 1);
    cyc(5'b00100, 0, 0);
    chk("nest_hold_lo", int_req, 0);
    cyc(5'b00100, 0, 1);
    cyc(5'b00100, 0, 0);
    chk("nest_ie1_req", int_req, 1);
    chk("nest_ie1_vec", int_vec, 16'h0013);
    ip_reg = 8'h00;

    do_reset();
    ie_reg = 8'h82;
    cyc(5'b00010, 0, 0);
    chk("wd_req", int_req, 1);
    ie_reg = 8'h02;
    cyc(5'b00010, 0, 0);
    chk("wd_drop", int_req, 0);
    chk("wd_clr", clr_flag, 0);
    ie_reg = 8'h82;
    cyc(5'b00010, 0, 0);
    chk("wd_no_svc", int_req, 1);
    do_reset();
    chk("rst_req_mid", int_req, 0);
    chk("rst_vec_mid", int_vec, 16'h0000);
    chk("rst_clr_mid", clr_flag, 0);

`ifdef INT_ACK_TIMEOUT_EN
    ie_reg = 8'h82;
    cyc(5'b00010, 0, 0);
    for (int k = 0; k < 15; k++) cyc(5'b00010, 0, 0);
    chk("to_still_req", int_req, 1);
    cyc(5'b00010, 0, 0);
    chk("to_drop", int_req, 0);
    chk("to_flag", timeout, 1);
    cyc(5'b00000, 0, 0);
    cyc(5'b00000, 0, 0);
    chk("to_sticky", timeout, 1);
    do_reset();
    chk("to_rst", timeout, 0);
`endif

    irq = '0;
    for (int n = 0; n < 3000; n++) begin
      irq = irq & ~exp_clr;
      if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, 4)] = 1'b1;
      if ($urandom_range(0, 9) == 0) irq[$urandom_range(0, 4)] = 1'b0;
      if ($urandom_range(0, 15) == 0) ie_reg = {($urandom_range(0, 7) != 0), 2'b00, 5'($urandom)};
      if ($urandom_range(0, 15) == 0) ip_reg = {3'b000, 5'($urandom)};
      if ($urandom_range(0, 15) == 0) it = 2'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      irq_src = irq;
      int_ack = ($urandom_range(0, 2) == 0);
      reti = ($urandom_range(0, 5) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
